// File: rtl/turn_signal_input_ctrl.sv
// Driver-control conditioning ahead of the tail-light sequencer: synchronise,
// debounce, hazard push-on/push-off latch and left/right mutual exclusion.
module turn_signal_input_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic stalk_l_raw,
  input  logic stalk_r_raw,
  input  logic haz_btn_raw,
  input  logic ign_raw,
  output logic lt,
  output logic rt,
  output logic haz,
  output logic stalk_fault
);

  localparam logic [0:0] HZ_OFF = 1'b0;
  localparam logic [0:0] HZ_ON  = 1'b1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit order: 0 = left stalk, 1 = right stalk, 2 = hazard button, 3 = ignition
  logic [3:0] raw_vec;
  logic [3:0] s1_q;
  logic [3:0] s2_q;

  logic [2:0]       stable_q;
  logic [2:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic [0:0] hz_state_q;
  logic [0:0] hz_state_d;
  logic       haz_rise;

  assign raw_vec = {ign_raw, haz_btn_raw, stalk_r_raw, stalk_l_raw};

  // A mismatch must persist for DEB_CYCLES consecutive edges before the
  // stable value flips; any return to the stable value restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Toggle on the same edge the debounced button goes high.
  assign haz_rise   = stable_d[2] & ~stable_q[2];
  assign hz_state_d = haz_rise ? ~hz_state_q : hz_state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      hz_state_q <= HZ_OFF;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= raw_vec;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      hz_state_q <= hz_state_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign haz         = (hz_state_q == HZ_ON);
  assign stalk_fault = stable_q[0] & stable_q[1];
  assign lt          = s2_q[3] & stable_q[0] & ~stable_q[1] & ~haz;
  assign rt          = s2_q[3] & stable_q[1] & ~stable_q[0] & ~haz;

endmodule

// File: tb/tb_turn_signal_input_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed {lt,rt,haz,stalk_fault}
// for specific cycles; a negedge monitor pops and compares them.
module tb_turn_signal_input_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic stalk_l_raw, stalk_r_raw, haz_btn_raw, ign_raw;
  logic lt, rt, haz, stalk_fault;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  v;
    logic [15:0] id;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;

  turn_signal_input_ctrl #(.DEB_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .stalk_l_raw(stalk_l_raw), .stalk_r_raw(stalk_r_raw),
    .haz_btn_raw(haz_btn_raw), .ign_raw(ign_raw),
    .lt(lt), .rt(rt), .haz(haz), .stalk_fault(stalk_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && int'(q[0].cyc) <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (int'(e.cyc) != cyc) begin
        errors++;
        $display("FAIL chk%0d missed: due cycle %0d, seen at %0d", e.id, e.cyc, cyc);
      end else if ({lt, rt, haz, stalk_fault} !== e.v) begin
        errors++;
        $display("FAIL chk%0d cyc=%0d lt/rt/haz/flt got=%b exp=%b",
                 e.id, cyc, {lt, rt, haz, stalk_fault}, e.v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int off, input logic [3:0] v);
    exp_t e;
    e.cyc = 32'(cyc + off);
    e.v   = v;
    e.id  = 16'(next_id);
    next_id++;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    stalk_l_raw = 1'b0; stalk_r_raw = 1'b0; haz_btn_raw = 1'b0; ign_raw = 1'b1;
    tick(1);
    exp_at(0, 4'b0000);
    exp_at(1, 4'b0000);
    tick(2);
    rst = 1'b1;
    tick(3);

    // 1: left stalk held -> lt on edge 6
    stalk_l_raw = 1'b1;
    exp_at(5, 4'b0000); exp_at(6, 4'b1000);
    tick(8);
    stalk_l_raw = 1'b0;
    exp_at(5, 4'b1000); exp_at(6, 4'b0000);
    tick(8);

    // 2: 3-cycle glitch rejected
    stalk_l_raw = 1'b1;
    for (int i = 1; i <= 10; i++) exp_at(i, 4'b0000);
    tick(3);
    stalk_l_raw = 1'b0;
    tick(8);

    // 3: hazard toggle with right stalk held
    haz_btn_raw = 1'b1; stalk_r_raw = 1'b1;
    exp_at(5, 4'b0000); exp_at(6, 4'b0010);
    tick(10);
    haz_btn_raw = 1'b0;
    exp_at(6, 4'b0010); exp_at(8, 4'b0010);
    tick(10);
    haz_btn_raw = 1'b1;
    exp_at(5, 4'b0010); exp_at(6, 4'b0100);
    tick(10);
    haz_btn_raw = 1'b0;
    exp_at(8, 4'b0100);
    tick(10);
    stalk_r_raw = 1'b0;
    exp_at(5, 4'b0100); exp_at(6, 4'b0000);
    tick(8);

    // 4: both stalks -> fault; release right -> lt
    stalk_l_raw = 1'b1; stalk_r_raw = 1'b1;
    exp_at(5, 4'b0000); exp_at(6, 4'b0001);
    tick(8);
    stalk_r_raw = 1'b0;
    exp_at(5, 4'b0001); exp_at(6, 4'b1000);
    tick(8);

    // 5: ignition off gates lt, hazard still works
    ign_raw = 1'b0;
    exp_at(1, 4'b1000); exp_at(2, 4'b0000);
    tick(4);
    haz_btn_raw = 1'b1;
    exp_at(5, 4'b0000); exp_at(6, 4'b0010);
    tick(8);
    haz_btn_raw = 1'b0;
    tick(8);
    haz_btn_raw = 1'b1;
    exp_at(5, 4'b0010); exp_at(6, 4'b0000);
    tick(8);
    haz_btn_raw = 1'b0;
    tick(8);
    ign_raw = 1'b1;
    exp_at(1, 4'b0000); exp_at(2, 4'b1000);
    tick(4);

    // 6: async reset mid-debounce with hazard on
    haz_btn_raw = 1'b1;
    exp_at(6, 4'b0010);
    tick(8);
    haz_btn_raw = 1'b0;
    tick(8);
    stalk_r_raw = 1'b1;
    tick(4);
    rst = 1'b0;
    exp_at(0, 4'b0000);
    tick(2);
    rst = 1'b1;
    exp_at(5, 4'b0000); exp_at(6, 4'b0001);
    tick(8);
    stalk_r_raw = 1'b0;
    exp_at(5, 4'b0001); exp_at(6, 4'b1000);
    tick(8);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
